// File: rtl/rib_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rib_rr_arbiter_pkg
// Description : Shared rib bus widths, arbiter state encoding and a small
//               index-width helper used by the round-robin arbiter and its
//               priority selector.
// Revision    : 1.0 - initial release
// ============================================================================
package rib_rr_arbiter_pkg;

  localparam int RIB_ADDR_W = 32;
  localparam int RIB_DATA_W = 32;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  // Width of an index into an n-entry vector; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rib_rr_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rib_rr_arbiter_rr_pick
// Description : Combinational round-robin priority selector. Scans the
//               request vector starting one position after the previous
//               winner, wrapping modulo N, and returns the first requester.
// Ports       : req   - request vector
//               last  - index of the previous winner
//               gnt   - one-hot winner (all zero when nothing requests)
//               idx   - index of the winner
//               valid - at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module rib_rr_arbiter_rr_pick
  import rib_rr_arbiter_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  logic [IDX_W-1:0] w_cand;
  logic             w_found;

  // The offset walks 1..N so the previous winner is examined last, which is
  // what gives every other requester priority over it.
  always_comb begin
    gnt     = '0;
    idx     = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int off = 1; off <= N; off++) begin
      w_cand = IDX_W'((int'(last) + off) % N);
      if (!w_found && req[w_cand]) begin
        w_found     = 1'b1;
        gnt[w_cand] = 1'b1;
        idx         = w_cand;
      end
    end
  end

  assign valid = w_found;

endmodule
`default_nettype wire

// File: rtl/rib_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rib_rr_arbiter
// Description : Round-robin arbiter with transaction lock sharing the single
//               rib slave-side port between NUM_M masters (0 = core ex,
//               1 = core fetch, then jtag and debug uart). The grant is held
//               until the slave acknowledges or a watchdog expires, in which
//               case the master receives an error completion.
// Ports       : clk, rst         - clock, asynchronous active-low reset
//               m_req_i/we/addr/wdata - packed per-master request side
//               m_rdata_o/ack/err    - completion back to the granted master
//               grant_o           - one-hot owner, zero while idle
//               s_*               - slave-side request/response
//               hold_flag_o       - core bus-hold request
// Revision    : 1.0 - initial release
// ============================================================================
module rib_rr_arbiter
  import rib_rr_arbiter_pkg::*;
#(
  parameter int               NUM_M     = 4,
  parameter int               TIMEOUT   = 255,
  parameter logic [NUM_M-1:0] HOLD_MASK = NUM_M'(4'b0011)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_M-1:0]            m_req_i,
  input  logic [NUM_M-1:0]            m_we_i,
  input  logic [NUM_M*RIB_ADDR_W-1:0] m_addr_i,
  input  logic [NUM_M*RIB_DATA_W-1:0] m_wdata_i,
  output logic [RIB_DATA_W-1:0]       m_rdata_o,
  output logic [NUM_M-1:0]            m_ack_o,
  output logic [NUM_M-1:0]            m_err_o,
  output logic [NUM_M-1:0]            grant_o,
  output logic                        s_req_o,
  output logic                        s_we_o,
  output logic [RIB_ADDR_W-1:0]       s_addr_o,
  output logic [RIB_DATA_W-1:0]       s_wdata_o,
  input  logic [RIB_DATA_W-1:0]       s_rdata_i,
  input  logic                        s_ack_i,
  output logic                        hold_flag_o
);

  localparam int IDX_W = idx_w(NUM_M);
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  // --------------------------------------------------------------------------
  // State and latched transaction
  // --------------------------------------------------------------------------
  arb_state_e             r_state,      w_state_nxt;
  logic [NUM_M-1:0]       r_grant,      w_grant_nxt;
  logic [IDX_W-1:0]       r_grant_idx,  w_grant_idx_nxt;
  logic [IDX_W-1:0]       r_last_grant, w_last_nxt;
  logic [TMR_W-1:0]       r_timer,      w_timer_nxt;
  logic                   r_we,         w_we_nxt;
  logic [RIB_ADDR_W-1:0]  r_addr,       w_addr_nxt;
  logic [RIB_DATA_W-1:0]  r_wdata,      w_wdata_nxt;

  logic [NUM_M-1:0]       w_pick_gnt;
  logic [IDX_W-1:0]       w_pick_idx;
  logic                   w_pick_valid;

  logic                   w_busy;
  logic                   w_timeout;
  logic                   w_done;

  rib_rr_arbiter_rr_pick #(
    .N     (NUM_M),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (m_req_i),
    .last  (r_last_grant),
    .gnt   (w_pick_gnt),
    .idx   (w_pick_idx),
    .valid (w_pick_valid)
  );

  assign w_busy    = (r_state == ARB_BUSY);
  // A real ack in the final watchdog cycle wins over the error completion.
  assign w_timeout = w_busy & ~s_ack_i & (r_timer == TMR_W'(TIMEOUT - 1));
  assign w_done    = w_busy & (s_ack_i | w_timeout);

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt     = r_state;
    w_grant_nxt     = r_grant;
    w_grant_idx_nxt = r_grant_idx;
    w_last_nxt      = r_last_grant;
    w_timer_nxt     = r_timer;
    w_we_nxt        = r_we;
    w_addr_nxt      = r_addr;
    w_wdata_nxt     = r_wdata;

    case (r_state)
      ARB_IDLE: begin
        if (w_pick_valid) begin
          w_state_nxt     = ARB_BUSY;
          w_grant_nxt     = w_pick_gnt;
          w_grant_idx_nxt = w_pick_idx;
          w_timer_nxt     = '0;
          // Capture the winner's request so the slave sees stable values
          // even if the master changes its inputs mid-transaction.
          w_we_nxt        = m_we_i[w_pick_idx];
          w_addr_nxt      = m_addr_i[w_pick_idx*RIB_ADDR_W +: RIB_ADDR_W];
          w_wdata_nxt     = m_wdata_i[w_pick_idx*RIB_DATA_W +: RIB_DATA_W];
        end
      end

      ARB_BUSY: begin
        if (w_done) begin
          // Completion, normal or watchdog, always advances the rotation so a
          // stuck slave cannot pin priority on one master.
          w_state_nxt = ARB_IDLE;
          w_grant_nxt = '0;
          w_last_nxt  = r_grant_idx;
          w_timer_nxt = '0;
        end else begin
          w_timer_nxt = r_timer + TMR_W'(1);
        end
      end

      default: begin
        w_state_nxt = ARB_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ARB_IDLE;
      r_grant      <= '0;
      r_grant_idx  <= '0;
      r_last_grant <= IDX_W'(NUM_M - 1);
      r_timer      <= '0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_grant_idx  <= w_grant_idx_nxt;
      r_last_grant <= w_last_nxt;
      r_timer      <= w_timer_nxt;
      r_we         <= w_we_nxt;
      r_addr       <= w_addr_nxt;
      r_wdata      <= w_wdata_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign grant_o   = r_grant;
  assign s_req_o   = w_busy;
  assign s_we_o    = r_we;
  assign s_addr_o  = r_addr;
  assign s_wdata_o = r_wdata;

  assign m_ack_o   = w_done    ? r_grant : '0;
  assign m_err_o   = w_timeout ? r_grant : '0;
  assign m_rdata_o = (w_busy & s_ack_i) ? s_rdata_i : '0;

  // Combinational so the core sees the stall released in its ack cycle;
  // qualified by reset because the request inputs are not under reset.
  assign hold_flag_o = rst & (|(HOLD_MASK & m_req_i & ~m_ack_o));

endmodule
`default_nettype wire

// File: tb/tb_rib_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rib_rr_arbiter
// Description : Self-checking bench for rib_rr_arbiter. Stimulus issues
//               batches of simultaneous master requests; the expected
//               completion order is derived from the round-robin rule and
//               queued, and an independent monitor compares every slave-side
//               cycle and every completion against the queue head.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rib_rr_arbiter;

  localparam int         NM = 4;
  localparam int         TO = 8;
  localparam logic [3:0] HM = 4'b0011;

  logic             clk;
  logic             rst;
  logic [NM-1:0]    m_req_i;
  logic [NM-1:0]    m_we_i;
  logic [NM*32-1:0] m_addr_i;
  logic [NM*32-1:0] m_wdata_i;
  logic [31:0]      m_rdata_o;
  logic [NM-1:0]    m_ack_o;
  logic [NM-1:0]    m_err_o;
  logic [NM-1:0]    grant_o;
  logic             s_req_o;
  logic             s_we_o;
  logic [31:0]      s_addr_o;
  logic [31:0]      s_wdata_o;
  logic [31:0]      s_rdata_i;
  logic             s_ack_i;
  logic             hold_flag_o;

  rib_rr_arbiter #(
    .NUM_M     (NM),
    .TIMEOUT   (TO),
    .HOLD_MASK (HM)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .m_req_i     (m_req_i),
    .m_we_i      (m_we_i),
    .m_addr_i    (m_addr_i),
    .m_wdata_i   (m_wdata_i),
    .m_rdata_o   (m_rdata_o),
    .m_ack_o     (m_ack_o),
    .m_err_o     (m_err_o),
    .grant_o     (grant_o),
    .s_req_o     (s_req_o),
    .s_we_o      (s_we_o),
    .s_addr_o    (s_addr_o),
    .s_wdata_o   (s_wdata_o),
    .s_rdata_i   (s_rdata_i),
    .s_ack_i     (s_ack_i),
    .hold_flag_o (hold_flag_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          m;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          busy;   // BUSY cycles up to and including the completion
  } exp_t;

  exp_t        sb[$];
  int          n_tests;
  int          n_fail;
  int          rr_ptr;
  int          force_lat;
  bit          force_mute;
  bit          force_rd_en;
  logic [31:0] force_rd;
  bit          late_ack_req;
  int          scramble_pct;
  logic [31:0] a_addr  [NM];
  logic [31:0] a_wdata [NM];
  logic        a_we    [NM];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  // Slave behaviour: latency and silence come from the address unless a
  // directed test overrides them.
  function automatic int cfg_lat(input logic [31:0] a);
    return (force_lat >= 0) ? force_lat : int'(a[3:2]);
  endfunction

  function automatic bit cfg_mute(input logic [31:0] a);
    return force_mute || (force_lat < 0 && a[9:8] == 2'b11);
  endfunction

  function automatic logic [31:0] rd_of(input logic [31:0] a);
    return force_rd_en ? force_rd : (a ^ 32'h5A5A_A5A5);
  endfunction

  function automatic void expect_txn(input int k);
    exp_t e;
    e.m     = k;
    e.we    = a_we[k];
    e.addr  = a_addr[k];
    e.wdata = a_wdata[k];
    e.err   = cfg_mute(a_addr[k]);
    e.rdata = e.err ? 32'd0 : rd_of(a_addr[k]);
    e.busy  = e.err ? TO : cfg_lat(a_addr[k]) + 1;
    sb.push_back(e);
  endfunction

  // --------------------------------------------------------------------------
  // Slave model
  // --------------------------------------------------------------------------
  initial begin
    int cnt;
    cnt       = 0;
    s_ack_i   = 1'b0;
    s_rdata_i = '0;
    forever begin
      @(posedge clk);
      #1;
      if (s_req_o) begin
        s_ack_i   = !cfg_mute(s_addr_o) && (cnt == cfg_lat(s_addr_o));
        s_rdata_i = s_ack_i ? rd_of(s_addr_o) : $urandom;
        cnt++;
      end else begin
        cnt          = 0;
        s_ack_i      = late_ack_req;
        late_ack_req = 1'b0;
        s_rdata_i    = $urandom;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Monitor / scoreboard
  // --------------------------------------------------------------------------
  initial begin
    int          busy_cnt;
    bit          prev_ack;
    exp_t        e;
    logic [31:0] oh;
    busy_cnt = 0;
    prev_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        busy_cnt = 0;
        prev_ack = 1'b0;
      end else begin
        if (prev_ack) chk("bubble_sreq", 32'(s_req_o), 32'd0);
        if (s_req_o) begin
          busy_cnt++;
          if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_unexpected_busy: grant 0x%h with nothing outstanding at %0t", grant_o, $time);
          end else begin
            e  = sb[0];
            oh = 32'd1 << e.m;
            chk("grant",   32'(grant_o), oh);
            chk("s_addr",  s_addr_o,     e.addr);
            chk("s_we",    32'(s_we_o),  32'(e.we));
            chk("s_wdata", s_wdata_o,    e.wdata);
            if (m_ack_o != '0) begin
              chk("m_ack",    32'(m_ack_o), oh);
              chk("m_err",    32'(m_err_o), e.err ? oh : 32'd0);
              chk("m_rdata",  m_rdata_o,    e.rdata);
              chk("ack_cyc",  32'(busy_cnt), 32'(e.busy));
              e = sb.pop_front();
            end else begin
              chk("busy_rdata", m_rdata_o,    32'd0);
              chk("busy_err",   32'(m_err_o), 32'd0);
              chk("ack_overdue", 32'(busy_cnt < e.busy), 32'd1);
            end
          end
        end else begin
          busy_cnt = 0;
          chk("idle_ack",   32'(m_ack_o), 32'd0);
          chk("idle_err",   32'(m_err_o), 32'd0);
          chk("idle_rdata", m_rdata_o,    32'd0);
          chk("idle_grant", 32'(grant_o), 32'd0);
        end
        prev_ack = (m_ack_o != '0);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  // Requests from every master in 'set' are raised together while the arbiter
  // is idle; each is dropped after its completion, so the service order is the
  // set walked once from the position after the previous owner.
  task automatic run_batch(input logic [NM-1:0] set);
    int cyc;
    for (int off = 1; off <= NM; off++) begin
      int k;
      k = (rr_ptr + off) % NM;
      if (set[k]) expect_txn(k);
    end
    for (int off = NM; off >= 1; off--) begin
      int k;
      k = (rr_ptr + off) % NM;
      if (set[k]) begin
        rr_ptr = k;
        break;
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < NM; k++) begin
      if (set[k]) begin
        m_req_i[k]            = 1'b1;
        m_we_i[k]             = a_we[k];
        m_addr_i[32*k +: 32]  = a_addr[k];
        m_wdata_i[32*k +: 32] = a_wdata[k];
      end
    end
    cyc = 0;
    while (m_req_i != '0 && cyc < 300) begin
      @(negedge clk);
      #2;
      cyc++;
      for (int k = 0; k < NM; k++) begin
        if (m_ack_o[k]) begin
          m_req_i[k] = 1'b0;
        end else if (m_req_i[k] && grant_o[k] && ($urandom_range(99, 0) < scramble_pct)) begin
          m_we_i[k]             = ~m_we_i[k];
          m_addr_i[32*k +: 32]  = $urandom;
          m_wdata_i[32*k +: 32] = $urandom;
        end
      end
    end
    if (m_req_i != '0) begin
      n_tests++;
      n_fail++;
      $display("FAIL batch_timeout: requests 0x%h still pending after %0d cycles", m_req_i, cyc);
      m_req_i = '0;
      sb.delete();
    end
  endtask

  task automatic randomize_masters();
    for (int k = 0; k < NM; k++) begin
      a_addr[k]  = $urandom;
      a_wdata[k] = $urandom;
      a_we[k]    = 1'($urandom_range(1, 0));
    end
  endtask

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    rr_ptr       = NM - 1;
    force_lat    = -1;
    force_mute   = 1'b0;
    force_rd_en  = 1'b0;
    force_rd     = '0;
    late_ack_req = 1'b0;
    scramble_pct = 0;
    m_req_i      = '0;
    m_we_i       = '0;
    m_addr_i     = '0;
    m_wdata_i    = '0;
    rst          = 1'b0;
    randomize_masters();

    // Reset state, with requests present to show the hold flag is gated.
    repeat (3) @(posedge clk);
    #1;
    m_req_i = 4'b1111;
    #1;
    chk("rst_sreq",  32'(s_req_o),     32'd0);
    chk("rst_grant", 32'(grant_o),     32'd0);
    chk("rst_ack",   32'(m_ack_o),     32'd0);
    chk("rst_err",   32'(m_err_o),     32'd0);
    chk("rst_hold",  32'(hold_flag_o), 32'd0);
    chk("rst_rdata", m_rdata_o,        32'd0);
    chk("rst_saddr", s_addr_o,         32'd0);
    chk("rst_swe",   32'(s_we_o),      32'd0);
    chk("rst_swdat", s_wdata_o,        32'd0);
    m_req_i = '0;
    @(negedge clk);
    rst = 1'b1;

    // Fairness: all four request with immediate acks -> 0,1,2,3 then 0,1.
    force_lat = 0;
    randomize_masters();
    run_batch(4'b1111);
    run_batch(4'b0011);

    // Single read from master 2, ack two cycles after the request.
    force_lat   = 2;
    force_rd_en = 1'b1;
    force_rd    = 32'hDEAD_BEEF;
    a_addr[2]   = 32'h1000_0004;
    a_we[2]     = 1'b0;
    a_wdata[2]  = 32'h1111_1111;
    run_batch(4'b0100);
    force_rd_en = 1'b0;

    // Watchdog on master 2, then a late ack during the idle bubble.
    force_mute = 1'b1;
    a_addr[2]  = 32'h2000_0010;
    run_batch(4'b0100);
    late_ack_req = 1'b1;
    repeat (3) @(posedge clk);
    force_mute = 1'b0;

    // Master 3 write whose inputs change after it is granted.
    force_lat    = 3;
    scramble_pct = 100;
    a_we[3]      = 1'b1;
    a_addr[3]    = 32'h3000_0000;
    a_wdata[3]   = 32'h0000_00A5;
    run_batch(4'b1000);
    scramble_pct = 0;

    // Hold flag: master 2 owns the bus for five cycles while master 0 waits.
    force_lat = 4;
    a_addr[2] = 32'h4000_0008; a_we[2] = 1'b0; a_wdata[2] = 32'h2222_2222;
    a_addr[0] = 32'h5000_000C; a_we[0] = 1'b1; a_wdata[0] = 32'h0000_0F0F;
    expect_txn(2);
    expect_txn(0);
    rr_ptr = 0;
    @(posedge clk);
    #1;
    m_req_i[2] = 1'b1;
    m_we_i[2] = a_we[2]; m_addr_i[64 +: 32] = a_addr[2]; m_wdata_i[64 +: 32] = a_wdata[2];
    @(posedge clk);
    #1;
    m_req_i[0] = 1'b1;
    m_we_i[0] = a_we[0]; m_addr_i[0 +: 32] = a_addr[0]; m_wdata_i[0 +: 32] = a_wdata[0];
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      chk($sformatf("hold_c%0d", c), 32'(hold_flag_o), 32'(c < 11));
      #2;
      if (c == 5)  m_req_i[2] = 1'b0;
      if (c == 11) m_req_i[0] = 1'b0;
    end

    // Reset in the middle of a busy transaction.
    force_mute = 1'b1;
    a_addr[2]  = 32'h6000_0000;
    expect_txn(2);
    @(posedge clk);
    #1;
    m_addr_i[64 +: 32] = a_addr[2];
    m_req_i = 4'b0101;
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("rstb_sreq",  32'(s_req_o),     32'd0);
    chk("rstb_grant", 32'(grant_o),     32'd0);
    chk("rstb_hold",  32'(hold_flag_o), 32'd0);
    chk("rstb_ack",   32'(m_ack_o),     32'd0);
    chk("rstb_err",   32'(m_err_o),     32'd0);
    sb.delete();
    rr_ptr  = NM - 1;
    m_req_i = '0;
    @(negedge clk);
    rst        = 1'b1;
    force_mute = 1'b0;
    force_lat  = 1;
    randomize_masters();
    run_batch(4'b0111);

    // Randomized batches with address-driven latency and occasional timeouts.
    force_lat    = -1;
    scramble_pct = 30;
    for (int b = 0; b < 40; b++) begin
      randomize_masters();
      run_batch(NM'($urandom_range(15, 1)));
    end

    repeat (3) @(posedge clk);
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
